// File: rtl/hdc_class_pkg.sv
// Shared constants and types for the HDC class-hypervector store and its neighbours.
package hdc_class_pkg;

  localparam int unsigned DefNumClasses = 8;
  localparam int unsigned DefDim        = 192;
  localparam int unsigned DefFrameW     = 64;

  typedef enum logic [1:0] {
    WR_REPLACE = 2'b00,
    WR_OR      = 2'b01,
    WR_XOR     = 2'b10,
    WR_ANDN    = 2'b11
  } wr_mode_e;

  typedef logic [0:0] state_t;
  localparam state_t StIdle   = 1'b0;
  localparam state_t StStream = 1'b1;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/class_hvec_mem_if.sv
// Request, stream-out and frame-write signals of the class-hypervector store.
interface class_hvec_mem_if #(
  parameter int unsigned NUM_CLASSES = hdc_class_pkg::DefNumClasses,
  parameter int unsigned DIM         = hdc_class_pkg::DefDim,
  parameter int unsigned FRAME_W     = hdc_class_pkg::DefFrameW
);
  localparam int unsigned NUM_FRAMES = DIM / FRAME_W;
  localparam int unsigned CLS_W      = hdc_class_pkg::idx_w(NUM_CLASSES);
  localparam int unsigned FRM_W      = hdc_class_pkg::idx_w(NUM_FRAMES);

  logic               req_valid;
  logic               req_ready;
  logic [CLS_W-1:0]   req_class;
  logic               out_valid;
  logic               out_ready;
  logic [FRAME_W-1:0] out_data;
  logic [CLS_W-1:0]   out_class;
  logic [FRM_W-1:0]   out_frame;
  logic               out_last;
  logic               wr_en;
  logic [1:0]         wr_mode;
  logic [CLS_W-1:0]   wr_class;
  logic [FRM_W-1:0]   wr_frame;
  logic [FRAME_W-1:0] wr_data;
  logic               clr;
  logic               err;
  logic               busy;

  modport master (
    output req_valid, req_class, out_ready, wr_en, wr_mode, wr_class, wr_frame, wr_data, clr,
    input  req_ready, out_valid, out_data, out_class, out_frame, out_last, err, busy
  );

  modport slave (
    input  req_valid, req_class, out_ready, wr_en, wr_mode, wr_class, wr_frame, wr_data, clr,
    output req_ready, out_valid, out_data, out_class, out_frame, out_last, err, busy
  );

endinterface

// File: rtl/class_frame_update.sv
// Combinational frame update f(old, data, mode), shared by the write and bypass paths.
module class_frame_update
  import hdc_class_pkg::*;
#(
  parameter int unsigned FRAME_W = DefFrameW
) (
  input  logic [FRAME_W-1:0] old_i,
  input  logic [FRAME_W-1:0] data_i,
  input  logic [1:0]         mode_i,
  output logic [FRAME_W-1:0] new_o
);

  always_comb begin
    new_o = data_i;
    unique case (wr_mode_e'(mode_i))
      WR_REPLACE: new_o = data_i;
      WR_OR:      new_o = old_i | data_i;
      WR_XOR:     new_o = old_i ^ data_i;
      WR_ANDN:    new_o = old_i & ~data_i;
      default:    new_o = data_i;
    endcase
  end

endmodule

// File: rtl/class_hvec_mem.sv
// Writable class-hypervector store that streams one class frame-by-frame on request.
module class_hvec_mem
  import hdc_class_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = DefNumClasses,
  parameter int unsigned DIM         = DefDim,
  parameter int unsigned FRAME_W     = DefFrameW
) (
  input logic             clk,
  input logic             rst,
  class_hvec_mem_if.slave bus_io
);

  localparam int unsigned NUM_FRAMES = DIM / FRAME_W;
  localparam int unsigned CLS_W      = idx_w(NUM_CLASSES);
  localparam int unsigned FRM_W      = idx_w(NUM_FRAMES);
  localparam logic [FRM_W-1:0] LastFrm = FRM_W'(NUM_FRAMES - 1);

  logic [FRAME_W-1:0] mem_q [NUM_CLASSES][NUM_FRAMES];

  state_t             state_q, state_d;
  logic [CLS_W-1:0]   cls_q, cls_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  logic               req_in_range, wr_in_range;
  logic               wr_ok, bad_wr, bad_req, stream_done;
  logic [CLS_W-1:0]   wr_cls_idx;
  logic [FRM_W-1:0]   wr_frm_idx;
  logic [FRAME_W-1:0] wr_old, wr_new;
  logic               ld_en, ld_hit;
  logic [CLS_W-1:0]   ld_cls;
  logic [FRM_W-1:0]   ld_frm;
  logic [FRAME_W-1:0] ld_word;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  assign req_in_range = 32'(bus_io.req_class) < NUM_CLASSES;
  assign wr_in_range  = (32'(bus_io.wr_class) < NUM_CLASSES) &&
                        (32'(bus_io.wr_frame) < NUM_FRAMES);

  // clr owns the cycle: a simultaneous write is dropped silently.
  assign wr_ok  = bus_io.wr_en && !bus_io.clr && wr_in_range;
  assign bad_wr = bus_io.wr_en && !bus_io.clr && !wr_in_range;

  assign wr_cls_idx = wr_in_range ? bus_io.wr_class : '0;
  assign wr_frm_idx = wr_in_range ? bus_io.wr_frame : '0;
  assign wr_old     = mem_q[wr_cls_idx][wr_frm_idx];

  class_frame_update #(
    .FRAME_W (FRAME_W)
  ) u_update (
    .old_i  (wr_old),
    .data_i (bus_io.wr_data),
    .mode_i (bus_io.wr_mode),
    .new_o  (wr_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
          mem_q[c][f] <= '0;
        end
      end
    end else if (bus_io.clr) begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
        for (int unsigned f = 0; f < NUM_FRAMES; f++) begin
          mem_q[c][f] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem_q[wr_cls_idx][wr_frm_idx] <= wr_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ld_en       = 1'b0;
    ld_cls      = cls_q;
    ld_frm      = frm_q;
    bad_req     = 1'b0;
    stream_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.req_valid) begin
          if (req_in_range) begin
            ld_en   = 1'b1;
            ld_cls  = bus_io.req_class;
            ld_frm  = '0;
            state_d = StStream;
          end else begin
            bad_req = 1'b1;
          end
        end
      end
      StStream: begin
        if (bus_io.out_ready) begin
          if (last_q) begin
            state_d     = StIdle;
            stream_done = 1'b1;
          end else begin
            ld_en  = 1'b1;
            ld_frm = frm_q + FRM_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-first bypass: a word updated or cleared this cycle is loaded post-update.
  assign ld_hit  = wr_ok && (wr_cls_idx == ld_cls) && (wr_frm_idx == ld_frm);
  assign ld_word = bus_io.clr ? '0 : (ld_hit ? wr_new : mem_q[ld_cls][ld_frm]);

  always_comb begin
    cls_d   = cls_q;
    frm_d   = frm_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (ld_en) begin
      cls_d   = ld_cls;
      frm_d   = ld_frm;
      data_d  = ld_word;
      valid_d = 1'b1;
      last_d  = (ld_frm == LastFrm);
    end else if (stream_done) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  assign err_d = bad_req | bad_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cls_q   <= '0;
      frm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      frm_q   <= frm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.req_ready = (state_q == StIdle);
  assign bus_io.busy      = (state_q == StStream);
  assign bus_io.out_valid = valid_q;
  assign bus_io.out_data  = data_q;
  assign bus_io.out_class = cls_q;
  assign bus_io.out_frame = frm_q;
  assign bus_io.out_last  = last_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_class_hvec_mem.sv
// Scoreboard bench for class_hvec_mem: directed scenarios then randomized traffic.
module tb_class_hvec_mem;
  import hdc_class_pkg::*;

  localparam int NC  = 8;
  localparam int DIM = 192;
  localparam int FW  = 64;
  localparam int NF  = DIM / FW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  class_hvec_mem_if #(.NUM_CLASSES(NC), .DIM(DIM), .FRAME_W(FW)) bus ();
  class_hvec_mem #(.NUM_CLASSES(NC), .DIM(DIM), .FRAME_W(FW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  // Non-power-of-two class count so an out-of-range request is expressible.
  class_hvec_mem_if #(.NUM_CLASSES(6), .DIM(128), .FRAME_W(64)) bus6 ();
  class_hvec_mem #(.NUM_CLASSES(6), .DIM(128), .FRAME_W(64)) dut6 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus6.slave)
  );

  typedef struct {
    int          cls;
    int          frm;
    logic [63:0] data;
    bit          last;
  } exp_t;

  logic [63:0] mdl [NC][NF];
  exp_t        exp_q [$];
  bit          m_valid;
  bit          m_err;
  int          m_cls;
  int          m_frm;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] apply(input logic [63:0] old, input logic [63:0] d,
                                        input logic [1:0] m);
    case (m)
      2'b00:   return d;
      2'b01:   return old | d;
      2'b10:   return old ^ d;
      default: return old & ~d;
    endcase
  endfunction

  // Predicts the effect of the next rising edge from the inputs now on the bus.
  task automatic model_step();
    bit ld = 0, bad_req = 0, wr_good;
    int lc = 0, lf = 0;
    if (rst) begin
      foreach (mdl[c, f]) mdl[c][f] = '0;
      m_valid = 0;
      m_err   = 0;
      exp_q.delete();
      return;
    end
    if (m_valid) begin
      if (bus.out_ready) begin
        if (m_frm == NF - 1) m_valid = 0;
        else begin
          ld = 1; lc = m_cls; lf = m_frm + 1;
        end
      end
    end else if (bus.req_valid) begin
      if (int'(bus.req_class) < NC) begin
        ld = 1; lc = int'(bus.req_class); lf = 0;
      end else bad_req = 1;
    end
    wr_good = bus.wr_en && (int'(bus.wr_class) < NC) && (int'(bus.wr_frame) < NF);
    if (bus.clr) foreach (mdl[c, f]) mdl[c][f] = '0;
    else if (wr_good)
      mdl[bus.wr_class][bus.wr_frame] =
        apply(mdl[bus.wr_class][bus.wr_frame], bus.wr_data, bus.wr_mode);
    if (ld) begin
      exp_q.push_back('{cls: lc, frm: lf, data: mdl[lc][lf], last: (lf == NF - 1)});
      m_valid = 1; m_cls = lc; m_frm = lf;
    end
    m_err = bad_req || (bus.wr_en && !bus.clr && !wr_good);
  endtask

  task automatic quiet();
    bus.req_valid = 0; bus.req_class = '0;
    bus.wr_en = 0; bus.wr_mode = '0; bus.wr_class = '0; bus.wr_frame = '0; bus.wr_data = '0;
    bus.clr = 0;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_write(input int c, input int f, input logic [1:0] m, input logic [63:0] d);
    quiet();
    bus.wr_en = 1; bus.wr_class = 3'(c); bus.wr_frame = 2'(f); bus.wr_mode = m; bus.wr_data = d;
    step();
  endtask

  task automatic do_req(input int c);
    quiet();
    bus.req_valid = 1; bus.req_class = 3'(c);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_valid; i++) begin
      quiet();
      step();
    end
    if (m_valid) begin
      errors++;
      $display("FAIL drain_timeout: stream still open, expected it closed");
    end
  endtask

  task automatic apply_reset();
    quiet();
    rst = 1;
    model_step();
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    rst = 0;
    step();
  endtask

  // Monitor: control flags after each edge, frame contents between edges.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("busy", 64'(bus.busy), 64'(m_valid));
      check("req_ready", 64'(bus.req_ready), 64'(!m_valid));
      check("err", 64'(bus.err), 64'(m_err));
      @(negedge clk); #1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame: got frame %0d, expected none", bus.out_frame);
        end else begin
          e = exp_q[0];
          check("out_data", bus.out_data, e.data);
          check("out_class", 64'(bus.out_class), 64'(e.cls));
          check("out_frame", 64'(bus.out_frame), 64'(e.frm));
          check("out_last", 64'(bus.out_last), 64'(e.last));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    quiet();
    bus.out_ready = 1;
    bus6.req_valid = 0; bus6.req_class = '0; bus6.out_ready = 1; bus6.wr_en = 0;
    bus6.wr_mode = '0; bus6.wr_class = '0; bus6.wr_frame = '0; bus6.wr_data = '0; bus6.clr = 0;
    model_step();
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_data", bus.out_data, 64'(0));
    check("reset_out_class", 64'(bus.out_class), 64'(0));
    check("reset_out_frame", 64'(bus.out_frame), 64'(0));
    check("reset_out_last", 64'(bus.out_last), 64'(0));
    check("reset_err", 64'(bus.err), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    step();

    // Zero store streams three zero frames back-to-back.
    bus.out_ready = 1;
    do_req(3);
    drain();

    do_write(1, 0, WR_REPLACE, 64'h0002_0000_0000_0000);
    do_write(1, 0, WR_OR, 64'h1);
    do_req(1);
    drain();

    do_write(4, 2, WR_XOR, 64'h0400_0000_0000_0200);
    do_write(4, 2, WR_XOR, 64'h0400_0000_0000_0200);
    do_req(4);
    drain();

    // Backpressure on frame 0, then release.
    do_write(5, 1, WR_REPLACE, 64'hDEAD_BEEF_0000_0055);
    bus.out_ready = 0;
    do_req(5);
    for (int i = 0; i < 4; i++) begin quiet(); step(); end
    bus.out_ready = 1;
    drain();

    // Collisions: write to the presented frame, then write-first into the loading frame.
    do_write(6, 1, WR_REPLACE, 64'h1234);
    do_write(6, 0, WR_REPLACE, 64'hABCD);
    bus.out_ready = 0;
    do_req(6);
    do_write(6, 0, WR_XOR, 64'hF0);
    bus.out_ready = 1;
    do_write(6, 1, WR_REPLACE, 64'hFF);
    drain();

    // clr mid-stream, with a write in the same cycle that must be dropped.
    for (int f = 0; f < NF; f++) do_write(2, f, WR_REPLACE, 64'hA5A5_0000_0000_0001 + 64'(f));
    do_req(2);
    quiet();
    bus.clr = 1; bus.wr_en = 1; bus.wr_class = 3'd2; bus.wr_frame = 2'd2; bus.wr_data = 64'h77;
    step();
    drain();

    // Out-of-range frame index: dropped with an err pulse.
    do_write(0, 3, WR_REPLACE, 64'hFFFF);
    do_req(0);
    drain();

    // Reset mid-stream.
    do_write(7, 0, WR_REPLACE, 64'h9999);
    bus.out_ready = 0;
    do_req(7);
    apply_reset();
    bus.out_ready = 1;
    do_req(7);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      quiet();
      bus.req_valid = ($urandom_range(0, 9) < 3);
      bus.req_class = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.wr_en     = ($urandom_range(0, 9) < 4);
      bus.wr_mode   = 2'($urandom_range(0, 3));
      bus.wr_class  = 3'($urandom_range(0, 7));
      bus.wr_frame  = 2'($urandom_range(0, 3));
      bus.wr_data   = {$urandom, $urandom};
      bus.clr       = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 499) == 0) apply_reset();
      else step();
    end
    bus.out_ready = 1;
    drain();

    // Six-class instance: bad request, bad class write, then a short stream.
    quiet();
    bus6.req_valid = 1; bus6.req_class = 3'd6;
    step();
    check("c6_bad_req_err", 64'(bus6.err), 64'(1));
    check("c6_bad_req_valid", 64'(bus6.out_valid), 64'(0));
    check("c6_bad_req_ready", 64'(bus6.req_ready), 64'(1));
    bus6.req_valid = 0;
    bus6.wr_en = 1; bus6.wr_class = 3'd7; bus6.wr_frame = 1'b0; bus6.wr_data = 64'h5;
    step();
    check("c6_bad_wr_err", 64'(bus6.err), 64'(1));
    bus6.wr_class = 3'd5; bus6.wr_frame = 1'b1; bus6.wr_mode = WR_REPLACE; bus6.wr_data = 64'h1234;
    step();
    check("c6_good_wr_err", 64'(bus6.err), 64'(0));
    bus6.wr_en = 0;
    bus6.req_valid = 1; bus6.req_class = 3'd5;
    step();
    bus6.req_valid = 0;
    check("c6_f0_valid", 64'(bus6.out_valid), 64'(1));
    check("c6_f0_frame", 64'(bus6.out_frame), 64'(0));
    check("c6_f0_data", bus6.out_data, 64'(0));
    check("c6_f0_class", 64'(bus6.out_class), 64'(5));
    check("c6_f0_last", 64'(bus6.out_last), 64'(0));
    step();
    check("c6_f1_frame", 64'(bus6.out_frame), 64'(1));
    check("c6_f1_data", bus6.out_data, 64'h1234);
    check("c6_f1_last", 64'(bus6.out_last), 64'(1));
    step();
    check("c6_done_valid", 64'(bus6.out_valid), 64'(0));
    check("c6_done_ready", 64'(bus6.req_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
